// File: rtl/rx_bit_timer_sampler_pkg.sv
// Shared constants and helpers for the UART RX bit timer / sampler.
// Holds frame geometry (data width, start/stop bit indices), the legal
// oversampling ratios and the 2-of-3 majority function.
package uart_rx_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int PRESCALE_WIDTH = 6;
    localparam int EDGE_CNT_W     = 5;
    localparam int BIT_CNT_W      = 4;

    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_8  = PRESCALE_WIDTH'(8);
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_16 = PRESCALE_WIDTH'(16);
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_32 = PRESCALE_WIDTH'(32);

    localparam logic [BIT_CNT_W-1:0] BIT_START      = '0;
    // Stop-bit index: start + data bits (+ parity when enabled).
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_PAR   = BIT_CNT_W'(DATA_WIDTH + 2);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_NOPAR = BIT_CNT_W'(DATA_WIDTH + 1);

    // 2-of-3 vote.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Any prescale other than 16 or 32 runs the counters as if it were 8.
    function automatic logic [PRESCALE_WIDTH-1:0] effective_prescale(
        input logic [PRESCALE_WIDTH-1:0] prescale
    );
        case (prescale)
            PRESCALE_16: return PRESCALE_16;
            PRESCALE_32: return PRESCALE_32;
            default:     return PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/rx_bit_timer_sampler_if.sv
// Control/status bundle between the RX FSM side (master) and the bit timer /
// sampler (slave). Clock and reset stay outside the bundle.
interface rx_bit_timer_sampler_if;
    import uart_rx_pkg::*;

    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      par_en;
    logic                      cnt_en;
    logic                      dat_samp_en;
    logic [EDGE_CNT_W-1:0]     edge_cnt;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic                      sampled_bit;
    logic                      strt_glitch;
    logic                      frame_done;

    modport master (
        output RX_IN, prescale, par_en, cnt_en, dat_samp_en,
        input  edge_cnt, bit_cnt, sampled_bit, strt_glitch, frame_done
    );

    modport slave (
        input  RX_IN, prescale, par_en, cnt_en, dat_samp_en,
        output edge_cnt, bit_cnt, sampled_bit, strt_glitch, frame_done
    );

endinterface

// File: rtl/rx_bit_timer_sampler_voter.sv
// Three mid-bit capture flops and the registered majority vote.
// Captures happen at edge_cnt = H-1, H, H+1; the vote lands at H+2 and only
// if all three captures were taken with dat_samp_en high.
module rx_majority_voter
    import uart_rx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_line,
    input  logic                  dat_samp_en,
    input  logic [EDGE_CNT_W-1:0] edge_cnt,
    input  logic [EDGE_CNT_W-1:0] half,
    output logic                  sampled_bit,
    output logic                  vote_fire,
    output logic                  vote_value
);

    logic [2:0]            samp_q;
    logic [2:0]            valid_q;
    logic [EDGE_CNT_W-1:0] cap0_edge;
    logic [EDGE_CNT_W-1:0] cap2_edge;
    logic [EDGE_CNT_W-1:0] vote_edge;

    // Capture/vote edge positions and the vote strobe for this cycle.
    always_comb begin
        // NOTE: every signal driven here is assigned on every path, so no latch can be inferred.
        cap0_edge  = half - EDGE_CNT_W'(1);
        cap2_edge  = half + EDGE_CNT_W'(1);
        vote_edge  = half + EDGE_CNT_W'(2);
        vote_value = majority3(samp_q[0], samp_q[1], samp_q[2]);
        vote_fire  = (edge_cnt == vote_edge) && (&valid_q);
    end

    // Capture the line at the three mid-bit edges, then register the vote.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!RST) begin
            samp_q      <= 3'b111;
            valid_q     <= 3'b000;
            sampled_bit <= 1'b1;
        end else begin
            if (edge_cnt == cap0_edge) begin
                samp_q[0]  <= rx_line;
                valid_q[0] <= dat_samp_en;
            end
            if (edge_cnt == half) begin
                samp_q[1]  <= rx_line;
                valid_q[1] <= dat_samp_en;
            end
            if (edge_cnt == cap2_edge) begin
                samp_q[2]  <= rx_line;
                valid_q[2] <= dat_samp_en;
            end
            if (vote_fire) begin
                sampled_bit <= vote_value;
            end
        end
    end

endmodule

// File: rtl/rx_bit_timer_sampler.sv
// UART RX bit timer / sampler: oversample edge counter, frame bit counter,
// start-glitch and frame-done pulses, and the majority-vote sampler.
// Optional macro RX_SYNC_EN: when defined, RX_IN goes through a 2-flop
// synchronizer (reset to idle-high) before capture; otherwise it is used directly.
module rx_bit_timer_sampler
    import uart_rx_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    rx_bit_timer_sampler_if.slave  bus
);

    logic [PRESCALE_WIDTH-1:0] p_eff;
    logic [EDGE_CNT_W-1:0]     p_last;
    logic [EDGE_CNT_W-1:0]     half;
    logic [BIT_CNT_W-1:0]      last_bit;
    logic [EDGE_CNT_W-1:0]     edge_cnt_q;
    logic [BIT_CNT_W-1:0]      bit_cnt_q;
    logic                      strt_glitch_q;
    logic                      frame_done_q;
    logic                      rx_line;
    logic                      sampled_bit;
    logic                      vote_fire;
    logic                      vote_value;

`ifdef RX_SYNC_EN
    logic [1:0] rx_sync_q;

    // Two-stage synchronizer; resets to the idle-high line level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], bus.RX_IN};
        end
    end

    assign rx_line = rx_sync_q[1];
`else
    assign rx_line = bus.RX_IN;
`endif

    // Bit period, mid-bit point and stop-bit index from the current config.
    always_comb begin
        p_eff    = effective_prescale(bus.prescale);
        p_last   = EDGE_CNT_W'(p_eff - PRESCALE_WIDTH'(1));
        half     = EDGE_CNT_W'(p_eff >> 1);
        last_bit = bus.par_en ? LAST_BIT_PAR : LAST_BIT_NOPAR;
    end

    // Edge/bit counters and the two status pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            strt_glitch_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else if (!bus.cnt_en) begin
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            strt_glitch_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            strt_glitch_q <= vote_fire && vote_value && (bit_cnt_q == BIT_START);
            // >= rather than == so a mid-frame prescale/par_en change cannot strand the counters.
            if (edge_cnt_q >= p_last) begin
                edge_cnt_q <= '0;
                if (bit_cnt_q >= last_bit) begin
                    frame_done_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
                end
            end else begin
                edge_cnt_q <= edge_cnt_q + EDGE_CNT_W'(1);
            end
        end
    end

    rx_majority_voter u_voter (
        .CLK         (CLK),
        .RST         (RST),
        .rx_line     (rx_line),
        .dat_samp_en (bus.dat_samp_en),
        .edge_cnt    (edge_cnt_q),
        .half        (half),
        .sampled_bit (sampled_bit),
        .vote_fire   (vote_fire),
        .vote_value  (vote_value)
    );

    assign bus.edge_cnt    = edge_cnt_q;
    assign bus.bit_cnt     = bit_cnt_q;
    assign bus.sampled_bit = sampled_bit;
    assign bus.strt_glitch = strt_glitch_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_rx_bit_timer_sampler.sv
// Directed bench for rx_bit_timer_sampler (default build, RX_SYNC_EN undefined).
// After cnt_en rises, c counts clock edges; the DUT then shows edge_cnt = c % P
// and bit_cnt = c / P, and line values set after edge c are captured at edge c+1.
module tb_rx_bit_timer_sampler;
    import uart_rx_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    int   vectors     = 0;
    int   miscompares = 0;
    int   fd_count;
    int   b;
    int   e;
    logic [10:0] frame;
    logic [3:0]  t2_expect;

    rx_bit_timer_sampler_if bus_if ();

    rx_bit_timer_sampler dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST                = 1'b0;
        bus_if.RX_IN       = 1'b1;
        bus_if.prescale    = PRESCALE_8;
        bus_if.par_en      = 1'b0;
        bus_if.cnt_en      = 1'b0;
        bus_if.dat_samp_en = 1'b0;
        step();
        step();

        // Reset state
        check("rst_edge_cnt",    8'(bus_if.edge_cnt),    8'd0);
        check("rst_bit_cnt",     8'(bus_if.bit_cnt),     8'd0);
        check("rst_sampled_bit", 8'(bus_if.sampled_bit), 8'd1);
        check("rst_strt_glitch", 8'(bus_if.strt_glitch), 8'd0);
        check("rst_frame_done",  8'(bus_if.frame_done),  8'd0);
        RST = 1'b1;
        step();

        // 1: P=8, parity on, 0xA5 with even parity 0: {stop, parity, data, start}
        frame              = {1'b1, 1'b0, 8'hA5, 1'b0};
        bus_if.prescale    = PRESCALE_8;
        bus_if.par_en      = 1'b1;
        bus_if.dat_samp_en = 1'b1;
        bus_if.RX_IN       = frame[0];
        bus_if.cnt_en      = 1'b1;
        fd_count           = 0;
        for (int c = 1; c <= 88; c++) begin
            step();
            if (bus_if.frame_done) fd_count++;
            if (c <= 87) bus_if.RX_IN = frame[c / 8];
            if (c % 8 == 7) begin
                check($sformatf("t1_bit%0d_cnt", c / 8), 8'(bus_if.bit_cnt), 8'(c / 8));
                check($sformatf("t1_bit%0d_val", c / 8), 8'(bus_if.sampled_bit), 8'(frame[c / 8]));
            end
        end
        check("t1_frame_done",    8'(bus_if.frame_done), 8'd1);
        check("t1_done_bit_cnt",  8'(bus_if.bit_cnt),    8'd10);
        check("t1_done_edge_cnt", 8'(bus_if.edge_cnt),   8'd0);
        check("t1_done_count",    8'(fd_count),          8'd1);
        step();
        check("t1_done_cleared",  8'(bus_if.frame_done), 8'd0);
        check("t1_bit_cnt_holds", 8'(bus_if.bit_cnt),    8'd10);
        bus_if.cnt_en = 1'b0;
        step();
        check("t1_off_edge", 8'(bus_if.edge_cnt), 8'd0);
        check("t1_off_bit",  8'(bus_if.bit_cnt),  8'd0);

        // 2: P=16; bit1 high with low glitch at edge 8 -> 1; bit2 low with high
        //    glitch at edge 9 -> 0; bit3 high but dat_samp_en low at edge 8 -> vote skipped, holds 0
        t2_expect          = 4'b0010;
        bus_if.prescale    = PRESCALE_16;
        bus_if.par_en      = 1'b1;
        bus_if.RX_IN       = 1'b0;
        bus_if.dat_samp_en = 1'b1;
        bus_if.cnt_en      = 1'b1;
        for (int c = 1; c <= 63; c++) begin
            step();
            b = c / 16;
            e = c % 16;
            bus_if.dat_samp_en = 1'b1;
            case (b)
                0:       bus_if.RX_IN = 1'b0;
                1:       bus_if.RX_IN = (e == 8) ? 1'b0 : 1'b1;
                2:       bus_if.RX_IN = (e == 9) ? 1'b1 : 1'b0;
                default: begin
                    bus_if.RX_IN       = 1'b1;
                    bus_if.dat_samp_en = (e == 8) ? 1'b0 : 1'b1;
                end
            endcase
            if (c == 11) check("t2_no_strt_glitch", 8'(bus_if.strt_glitch), 8'd0);
            if (e == 15) check($sformatf("t2_bit%0d_val", b), 8'(bus_if.sampled_bit), 8'(t2_expect[b]));
        end
        bus_if.cnt_en      = 1'b0;
        bus_if.dat_samp_en = 1'b1;
        step();

        // 3: P=32, start bit low for only 10 clocks -> vote 1, strt_glitch after edge 18
        bus_if.prescale = PRESCALE_32;
        bus_if.par_en   = 1'b0;
        bus_if.RX_IN    = 1'b0;
        check("t3_idle_edge", 8'(bus_if.edge_cnt), 8'd0);
        bus_if.cnt_en   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            bus_if.RX_IN = (c < 10) ? 1'b0 : 1'b1;
            if (c == 18) begin
                check("t3_pre_strt",    8'(bus_if.strt_glitch), 8'd0);
                check("t3_pre_sampled", 8'(bus_if.sampled_bit), 8'd0);
            end
            if (c == 19) begin
                check("t3_strt_glitch", 8'(bus_if.strt_glitch), 8'd1);
                check("t3_sampled",     8'(bus_if.sampled_bit), 8'd1);
                check("t3_edge_cnt",    8'(bus_if.edge_cnt),    8'd19);
            end
            if (c == 20) check("t3_strt_pulse_end", 8'(bus_if.strt_glitch), 8'd0);
        end
        bus_if.cnt_en = 1'b0;
        step();

        // 4: P=8, cnt_en dropped at bit 4 / edge 5 -> counters clear, no frame_done
        bus_if.prescale = PRESCALE_8;
        bus_if.par_en   = 1'b1;
        bus_if.RX_IN    = 1'b0;
        bus_if.cnt_en   = 1'b1;
        for (int c = 1; c <= 37; c++) begin
            step();
            bus_if.RX_IN = (c < 8) ? 1'b0 : 1'b1;
        end
        check("t4_pre_edge", 8'(bus_if.edge_cnt), 8'd5);
        check("t4_pre_bit",  8'(bus_if.bit_cnt),  8'd4);
        bus_if.cnt_en = 1'b0;
        step();
        check("t4_edge_cleared", 8'(bus_if.edge_cnt),   8'd0);
        check("t4_bit_cleared",  8'(bus_if.bit_cnt),    8'd0);
        check("t4_no_done",      8'(bus_if.frame_done), 8'd0);
        fd_count = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (bus_if.frame_done) fd_count++;
        end
        check("t4_no_done_later", 8'(fd_count), 8'd0);

        // 5: P=8, no parity, all-zero frame; reset asserted at bit 6
        bus_if.par_en = 1'b0;
        bus_if.RX_IN  = 1'b0;
        bus_if.cnt_en = 1'b1;
        for (int c = 1; c <= 50; c++) step();
        check("t5_pre_bit",     8'(bus_if.bit_cnt),     8'd6);
        check("t5_pre_sampled", 8'(bus_if.sampled_bit), 8'd0);
        #1;
        RST = 1'b0;
        #1;
        check("t5_rst_edge",    8'(bus_if.edge_cnt),    8'd0);
        check("t5_rst_bit",     8'(bus_if.bit_cnt),     8'd0);
        check("t5_rst_sampled", 8'(bus_if.sampled_bit), 8'd1);
        check("t5_rst_strt",    8'(bus_if.strt_glitch), 8'd0);
        check("t5_rst_done",    8'(bus_if.frame_done),  8'd0);
        step();
        check("t5_in_rst_edge", 8'(bus_if.edge_cnt), 8'd0);
        RST = 1'b1;
        check("t5_rel_edge", 8'(bus_if.edge_cnt), 8'd0);
        check("t5_rel_bit",  8'(bus_if.bit_cnt),  8'd0);
        step();
        check("t5_restart_edge", 8'(bus_if.edge_cnt), 8'd1);
        check("t5_restart_bit",  8'(bus_if.bit_cnt),  8'd0);
        bus_if.cnt_en = 1'b0;
        step();

        // 6: illegal prescale 12 runs as 8; no parity -> frame_done at bit 9
        bus_if.prescale = PRESCALE_WIDTH'(12);
        bus_if.par_en   = 1'b0;
        bus_if.RX_IN    = 1'b0;
        bus_if.cnt_en   = 1'b1;
        fd_count        = 0;
        for (int c = 1; c <= 81; c++) begin
            step();
            if (bus_if.frame_done) fd_count++;
            bus_if.RX_IN = (c < 8) ? 1'b0 : 1'b1;
            if (c == 7) check("t6_edge_max", 8'(bus_if.edge_cnt), 8'd7);
            if (c == 8) begin
                check("t6_wrap_edge", 8'(bus_if.edge_cnt), 8'd0);
                check("t6_wrap_bit",  8'(bus_if.bit_cnt),  8'd1);
            end
            if (c == 80) begin
                check("t6_frame_done", 8'(bus_if.frame_done), 8'd1);
                check("t6_done_bit",   8'(bus_if.bit_cnt),    8'd9);
            end
            if (c == 81) begin
                check("t6_done_end",  8'(bus_if.frame_done), 8'd0);
                check("t6_bit_holds", 8'(bus_if.bit_cnt),    8'd9);
                check("t6_edge_post", 8'(bus_if.edge_cnt),   8'd1);
            end
        end
        check("t6_done_count", 8'(fd_count), 8'd1);
        bus_if.cnt_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
